// File: rtl/axi_bridge_arb.sv
`timescale 1ns / 1ps
// axi_bridge_arb
//   Merges icache reads, dcache reads and dcache writes onto one AXI4 master port.
//   Reads: dcache has strict priority over icache, one read outstanding, routed
//   back by the latched owner. Writes: one outstanding AW/W/B sequence.
//   A read to the 16-byte line of an in-flight write is held off until the
//   write response has been taken.
// Ports
//   clk, rstn             clock, asynchronous active-low reset
//   i_ar*/i_r*            icache read request / read data
//   d_ar*/d_r*            dcache read request / read data
//   d_aw*/d_w*/d_b*       dcache write address / data / response
//   m_ar*/m_r*            AXI4 master read address / read data
//   m_aw*/m_w*/m_b*       AXI4 master write address / data / response
//   axi_err               sticky: a non-OKAY RRESP or BRESP was accepted
module axi_bridge_arb #(
   parameter logic [3:0] ID_I = 4'd0,
   parameter logic [3:0] ID_D = 4'd1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        i_arvalid,
   input  logic [31:0] i_araddr,
   input  logic [7:0]  i_arlen,
   input  logic [2:0]  i_arsize,
   output logic        i_arready,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   output logic        i_rlast,
   input  logic        i_rready,
   input  logic        d_arvalid,
   input  logic [31:0] d_araddr,
   input  logic [7:0]  d_arlen,
   input  logic [2:0]  d_arsize,
   output logic        d_arready,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_rlast,
   input  logic        d_rready,
   input  logic        d_awvalid,
   input  logic [31:0] d_awaddr,
   input  logic [7:0]  d_awlen,
   input  logic [2:0]  d_awsize,
   output logic        d_awready,
   input  logic        d_wvalid,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   input  logic        d_wlast,
   output logic        d_wready,
   output logic        d_bvalid,
   input  logic        d_bready,
   output logic        m_arvalid,
   output logic [3:0]  m_arid,
   output logic [31:0] m_araddr,
   output logic [7:0]  m_arlen,
   output logic [2:0]  m_arsize,
   output logic [1:0]  m_arburst,
   input  logic        m_arready,
   input  logic        m_rvalid,
   input  logic [3:0]  m_rid,
   input  logic [31:0] m_rdata,
   input  logic [1:0]  m_rresp,
   input  logic        m_rlast,
   output logic        m_rready,
   output logic        m_awvalid,
   output logic [3:0]  m_awid,
   output logic [31:0] m_awaddr,
   output logic [7:0]  m_awlen,
   output logic [2:0]  m_awsize,
   output logic [1:0]  m_awburst,
   input  logic        m_awready,
   output logic        m_wvalid,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   output logic        m_wlast,
   input  logic        m_wready,
   input  logic        m_bvalid,
   input  logic [3:0]  m_bid,
   input  logic [1:0]  m_bresp,
   output logic        m_bready,
   output logic        axi_err
);

   typedef enum logic [1:0] {RIdle, RAr, RData} r_state_e;
   typedef enum logic [1:0] {WIdle, WAw, WData, WResp} w_state_e;

   r_state_e    r_state_q;
   w_state_e    w_state_q;
   logic        r_own_d_q;   // 1: current read belongs to the dcache
   logic        arvalid_q, awvalid_q, axi_err_q;
   logic [3:0]  arid_q, awid_q;
   logic [31:0] araddr_q, awaddr_q;
   logic [7:0]  arlen_q, awlen_q;
   logic [2:0]  arsize_q, awsize_q;

   logic w_busy, d_hazard, i_hazard, grant_d, grant_i;
   logic r_data, w_data, w_resp, own_d, own_i;

   // Responses are routed by the latched owner, so the returned IDs are not needed.
   logic unused_ids;
   assign unused_ids = ^{m_rid, m_bid};

   // Hazard compares against the latched write line, so a write accepted in
   // this same cycle cannot block this cycle's read.
   assign w_busy   = (w_state_q != WIdle);
   assign d_hazard = w_busy && (d_araddr[31:4] == awaddr_q[31:4]);
   assign i_hazard = w_busy && (i_araddr[31:4] == awaddr_q[31:4]);

   // Strict priority: a blocked dcache request stalls the icache as well.
   assign grant_d = (r_state_q == RIdle) && d_arvalid && !d_hazard;
   assign grant_i = (r_state_q == RIdle) && !d_arvalid && i_arvalid && !i_hazard;

   assign i_arready = grant_i;
   assign d_arready = grant_d;

   assign r_data = (r_state_q == RData);
   assign own_d  = r_data && r_own_d_q;
   assign own_i  = r_data && !r_own_d_q;

   assign m_rready = (own_d && d_rready) || (own_i && i_rready);
   assign d_rvalid = own_d && m_rvalid;
   assign d_rdata  = own_d ? m_rdata : '0;
   assign d_rlast  = own_d && m_rlast;
   assign i_rvalid = own_i && m_rvalid;
   assign i_rdata  = own_i ? m_rdata : '0;
   assign i_rlast  = own_i && m_rlast;

   assign m_arvalid = arvalid_q;
   assign m_arid    = arid_q;
   assign m_araddr  = araddr_q;
   assign m_arlen   = arlen_q;
   assign m_arsize  = arsize_q;
   assign m_arburst = 2'b01;

   assign w_data = (w_state_q == WData);
   assign w_resp = (w_state_q == WResp);

   assign d_awready = (w_state_q == WIdle) && d_awvalid;
   assign m_wvalid  = w_data && d_wvalid;
   assign m_wdata   = w_data ? d_wdata : '0;
   assign m_wstrb   = w_data ? d_wstrb : '0;
   assign m_wlast   = w_data && d_wlast;
   assign d_wready  = w_data && m_wready;
   assign d_bvalid  = w_resp && m_bvalid;
   assign m_bready  = w_resp && d_bready;

   assign m_awvalid = awvalid_q;
   assign m_awid    = awid_q;
   assign m_awaddr  = awaddr_q;
   assign m_awlen   = awlen_q;
   assign m_awsize  = awsize_q;
   assign m_awburst = 2'b01;

   assign axi_err = axi_err_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state_q <= RIdle;
         r_own_d_q <= 1'b0;
         arvalid_q <= 1'b0;
         arid_q    <= '0;
         araddr_q  <= '0;
         arlen_q   <= '0;
         arsize_q  <= '0;
      end else begin
         unique case (r_state_q)
            RIdle: begin
               if (grant_d || grant_i) begin
                  r_own_d_q <= grant_d;
                  arvalid_q <= 1'b1;
                  arid_q    <= grant_d ? ID_D : ID_I;
                  araddr_q  <= grant_d ? d_araddr : i_araddr;
                  arlen_q   <= grant_d ? d_arlen : i_arlen;
                  arsize_q  <= grant_d ? d_arsize : i_arsize;
                  r_state_q <= RAr;
               end
            end
            RAr: begin
               if (m_arready) begin
                  arvalid_q <= 1'b0;
                  r_state_q <= RData;
               end
            end
            RData: begin
               if (m_rvalid && m_rready && m_rlast) r_state_q <= RIdle;
            end
            default: r_state_q <= RIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         w_state_q <= WIdle;
         awvalid_q <= 1'b0;
         awid_q    <= '0;
         awaddr_q  <= '0;
         awlen_q   <= '0;
         awsize_q  <= '0;
      end else begin
         unique case (w_state_q)
            WIdle: begin
               if (d_awvalid) begin
                  awvalid_q <= 1'b1;
                  awid_q    <= ID_D;
                  awaddr_q  <= d_awaddr;
                  awlen_q   <= d_awlen;
                  awsize_q  <= d_awsize;
                  w_state_q <= WAw;
               end
            end
            WAw: begin
               if (m_awready) begin
                  awvalid_q <= 1'b0;
                  w_state_q <= WData;
               end
            end
            WData: begin
               if (d_wvalid && m_wready && d_wlast) w_state_q <= WResp;
            end
            WResp: begin
               if (m_bvalid && d_bready) w_state_q <= WIdle;
            end
            default: w_state_q <= WIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         axi_err_q <= 1'b0;
      end else if ((m_rvalid && m_rready && (m_rresp != 2'b00)) ||
                   (m_bvalid && m_bready && (m_bresp != 2'b00))) begin
         axi_err_q <= 1'b1;
      end
   end

endmodule
